iq_compact_buf: RTL

Synthesizable, parametrised issue-queue buffer holding decoded instructions between dispatch and issue. Accepts up to INS_COUNT entries per cycle in program order and presents the oldest EXT_COUNT entries as a registered window. Any subset of the window may be consumed out of order, and the survivors compact toward the head. A stream-selective, age-qualified flush removes wrong-path entries in the same cycle; all storage is a fixed register array with shift compaction.

---
 rtl/iq_compact_buf_if.sv | 52 +++++
 rtl/iq_compact_buf.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/iq_compact_buf_if.sv
// Entry type and bundled handshake interface for the compacting issue-queue buffer.
package iq_compact_buf_pkg;

    // Decoded instruction as held by the buffer; idx is the age tag stamped on insert.
    typedef struct packed {
        logic        stream;
        logic [6:0]  idx;
        logic [15:0] payload;
    } iq_entry_t;

endpackage

interface iq_compact_buf_if #(
    parameter type T         = iq_compact_buf_pkg::iq_entry_t,
    parameter int  DEPTH     = 16,
    parameter int  INS_COUNT = 4,
    parameter int  EXT_COUNT = 4,
    parameter int  IDX_W     = 7
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INS_W = $clog2(INS_COUNT + 1);

    logic                   ins_enable;
    logic [INS_W-1:0]       ins_count;
    T [INS_COUNT-1:0]       new_elements;
    logic                   ins_ready;
    logic                   ext_enable;
    logic [EXT_COUNT-1:0]   ext_consumed;
    logic [EXT_COUNT-1:0]   ext_valid;
    T [EXT_COUNT-1:0]       out_elements;
    logic                   flush;
    logic                   flush_stream;
    logic [IDX_W-1:0]       flush_idx;
    logic                   empty;
    logic                   full;
    logic [CNT_W-1:0]       used_count;

    modport master (
        output ins_enable, ins_count, new_elements,
        output ext_enable, ext_consumed,
        output flush, flush_stream, flush_idx,
        input  ins_ready, ext_valid, out_elements, empty, full, used_count
    );

    modport slave (
        input  ins_enable, ins_count, new_elements,
        input  ext_enable, ext_consumed,
        input  flush, flush_stream, flush_idx,
        output ins_ready, ext_valid, out_elements, empty, full, used_count
    );

endinterface

// File: rtl/iq_compact_buf.sv
// Issue-queue buffer: in-order insert, out-of-order consume from a head window,
// stream-selective age-qualified flush, all done by shift compaction of a slot array.
module iq_compact_buf #(
    parameter type T         = iq_compact_buf_pkg::iq_entry_t,
    parameter int  DEPTH     = 16,
    parameter int  INS_COUNT = 4,
    parameter int  EXT_COUNT = 4,
    parameter int  IDX_W     = 7
) (
    input  logic             clock,
    input  logic             reset,
    iq_compact_buf_if.slave  bus
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SLOT_W = $clog2(DEPTH);
    localparam int INS_W  = $clog2(INS_COUNT + 1);

    T                     slots_q [DEPTH];
    T                     slots_d [DEPTH];
    T                     kept    [DEPTH];
    T                     merged  [DEPTH];
    T                     new_entry;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [CNT_W-1:0]     kept_count;
    logic [CNT_W-1:0]     merged_count;
    logic [CNT_W-1:0]     ins_pos;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [IDX_W-1:0]     age;
    logic [EXT_COUNT-1:0] ext_valid_q;
    logic [EXT_COUNT-1:0] ext_valid_d;
    logic [DEPTH-1:0]     consume_mask;
    logic                 ins_ready_w;
    logic                 accept;
    logic                 kill;

    assign ins_ready_w = (count_q <= CNT_W'(DEPTH - INS_COUNT));
    assign accept      = bus.ins_enable && ins_ready_w && (bus.ins_count != '0);

    // Which head-window slots are being consumed this cycle (only live slots count).
    always_comb begin
        consume_mask = '0;
        for (int s = 0; s < EXT_COUNT; s++) begin
            consume_mask[s] = bus.ext_enable && bus.ext_consumed[s] && ext_valid_q[s];
        end
    end

    // Drop consumed slots and pack the survivors toward slot 0 in their original order.
    always_comb begin
        kept_count = '0;
        for (int s = 0; s < DEPTH; s++) begin
            kept[s] = '0;
        end
        for (int s = 0; s < DEPTH; s++) begin
            if ((CNT_W'(s) < count_q) && !consume_mask[s]) begin
                kept[kept_count[SLOT_W-1:0]] = slots_q[s];
                kept_count = kept_count + CNT_W'(1);
            end
        end
    end

    // Append accepted inserts behind the survivors, stamping consecutive age tags.
    always_comb begin
        ins_pos   = '0;
        new_entry = '0;
        for (int s = 0; s < DEPTH; s++) begin
            merged[s] = kept[s];
        end
        for (int i = 0; i < INS_COUNT; i++) begin
            ins_pos = kept_count + CNT_W'(i);
            if (accept && (INS_W'(i) < bus.ins_count) && (ins_pos < CNT_W'(DEPTH))) begin
                new_entry     = bus.new_elements[i];
                new_entry.idx = idx_q + IDX_W'(i);
                merged[ins_pos[SLOT_W-1:0]] = new_entry;
            end
        end
        merged_count = accept ? kept_count + CNT_W'(bus.ins_count) : kept_count;
        idx_d        = accept ? idx_q + IDX_W'(bus.ins_count) : idx_q;
    end

    // Remove wrong-path entries younger than flush_idx on the flushed stream, then pack again.
    always_comb begin
        count_d = '0;
        age     = '0;
        kill    = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            slots_d[s] = '0;
        end
        for (int s = 0; s < DEPTH; s++) begin
            age  = merged[s].idx - bus.flush_idx;
            kill = bus.flush && (merged[s].stream == bus.flush_stream) &&
                   (age != '0) && !age[IDX_W-1];
            if ((CNT_W'(s) < merged_count) && !kill) begin
                slots_d[count_d[SLOT_W-1:0]] = merged[s];
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    // Window validity for the next cycle follows the post-flush occupancy.
    always_comb begin
        for (int k = 0; k < EXT_COUNT; k++) begin
            ext_valid_d[k] = (CNT_W'(k) < count_d);
        end
    end

    // State update; reset wins over insert, consume and flush alike.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                slots_q[s] <= '0;
            end
            count_q     <= '0;
            idx_q       <= '0;
            ext_valid_q <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                slots_q[s] <= slots_d[s];
            end
            count_q     <= count_d;
            idx_q       <= idx_d;
            ext_valid_q <= ext_valid_d;
        end
    end

    // The extraction window is the head of the registered slot array.
    always_comb begin
        for (int k = 0; k < EXT_COUNT; k++) begin
            bus.out_elements[k] = slots_q[k];
        end
    end

    assign bus.ext_valid  = ext_valid_q;
    assign bus.used_count = count_q;
    assign bus.ins_ready  = ins_ready_w;
    assign bus.full       = !ins_ready_w;
    assign bus.empty      = (count_q == '0);

endmodule
